neuron_scan: RTL and testbench
==============================

Name: neuron_scan

Overview:
- Timestep sequencer and kernel-decay stage that sits directly upstream of the per-neuron amplitude store.
- On each timestep tick it sweeps every neuron index. For each index it:
  - issues a read request to the amplitude store;
  - takes back that neuron's two amplitudes one cycle later;
  - applies exponential decay by arithmetic shift;
  - forms the membrane value (A minus B) and compares it against a threshold.
- Per neuron it emits decayed kernels ker_a/ker_b, a write address and an output-spike strobe, all aligned for the store's write port.

Parameters:
- NEURON_NO, 2**8, number of time-multiplexed neurons; power of two.
- AMPL_WID, 12, amplitude/kernel width, unsigned.
- TAU_A_SH, 4, decay shift for amplitude A: A' = A - (A >> TAU_A_SH).
- TAU_B_SH, 2, decay shift for amplitude B, same form.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state clears while low.
- tick  in  1  one-cycle timestep strobe; starts a sweep.
- threshold  in  AMPL_WID  firing threshold, unsigned.
- ampl_a  in  AMPL_WID  amplitude A, valid the cycle after re.
- ampl_b  in  AMPL_WID  amplitude B, valid the cycle after re.
- re  out  1  read enable to amplitude store.
- rd_addr  out  $clog2(NEURON_NO)  read index.
- wr_addr  out  $clog2(NEURON_NO)  index for ker_a/ker_b/sp_out.
- ker_a  out  AMPL_WID  decayed amplitude A.
- ker_b  out  AMPL_WID  decayed amplitude B.
- ker_valid  out  1  ker_a/ker_b/wr_addr/sp_out valid this cycle.
- sp_out  out  1  neuron wr_addr fires this timestep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last neuron's output.
- spike_cnt  out  $clog2(NEURON_NO)+1  spikes in the last completed sweep.
- overrun  out  1  sticky; tick arrived while busy.

Behaviour:
- Reset values (while reset is low): all outputs 0; FSM in IDLE; counters 0; overrun cleared.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE: on tick go to SCAN with index 0, busy=1.
  - SCAN: re=1, rd_addr=index; index increments every cycle. After issuing NEURON_NO-1, go to DRAIN; re=0.
  - DRAIN: wait for the pipeline to empty (2 cycles), pulse done, go to IDLE; busy=0 in the same cycle done pulses.
- Pipeline latency:
  - Cycle t: re/rd_addr=n.
  - Cycle t+1: ampl data present. Decay and compare are computed combinationally from that data.
  - Cycle t+2: registered outputs ker_valid=1, wr_addr=n, ker_a, ker_b, sp_out.
  - One neuron per cycle, no bubbles. Full sweep: tick to done = NEURON_NO+3 cycles.
- Decay arithmetic:
  - ker_a = ampl_a - (ampl_a >> TAU_A_SH); ker_b likewise with TAU_B_SH.
  - Results are never negative and need no saturation.
  - Nonzero values below 2**TAU_SH do not decay (shift yields 0). A value of 1 stays 1. This is accepted.
- Membrane and spike:
  - v = {1'b0,ker_a} - {1'b0,ker_b}, computed as signed AMPL_WID+1.
  - sp_out=1 iff v is non-negative and v >= threshold.
  - A negative v never fires, including when threshold=0.
  - When sp_out=1, ker_a/ker_b are still the decayed values; the store clears them on sp_out.
- Outputs when ker_valid=0: ker_a, ker_b, sp_out and wr_addr are 0.
- spike_cnt:
  - An internal accumulator counts sp_out during the sweep.
  - It is copied to spike_cnt in the done cycle, then the accumulator clears.
  - spike_cnt holds between sweeps.
  - The width allows the all-fire count NEURON_NO.
- tick while busy (SCAN or DRAIN):
  - tick is ignored and overrun is set.
  - overrun is cleared only by reset.
  - A tick in the same cycle as done is also an overrun and is ignored.
- threshold is sampled per neuron in the compare cycle. Changing it mid-sweep affects only later neurons.
- Reset asserted mid-sweep:
  - re, ker_valid, busy and sp_out drop immediately.
  - No done pulse; spike_cnt returns to 0.
- Index wrap: the index counter is exactly $clog2(NEURON_NO) bits. The last index is NEURON_NO-1; there is no wrap into a second sweep.

Test Plan:
- Reset then single tick, all amplitudes 0, threshold=1 -> re high for 256 cycles with rd_addr 0..255; ker_valid 2 cycles behind; all ker=0; sp_out never; done at tick+259; spike_cnt=0.
- Neuron 5 with ampl_a=0x100, ampl_b=0x010, threshold=0x0E0 -> wr_addr=5: ker_a=0x0F0, ker_b=0x00C, v=0x0E4, sp_out=1; spike_cnt=1.
- Neuron 7 with ampl_a=0x010, ampl_b=0x080, threshold=0 -> ker_a=0x00F, ker_b=0x060, v negative, sp_out=0.
- Boundary decay: ampl_a=0xFFF, ampl_b=1, threshold=0xF00 -> ker_a=0xF00, ker_b=1, v=0xEFF, sp_out=0; then threshold=0xEFF -> sp_out=1.
- Second tick 100 cycles into a sweep -> overrun=1 and stays set; the sweep completes normally with a single done.
- reset low during SCAN at index 40 -> outputs 0 asynchronously, no done; the next tick restarts from index 0.
- All 256 neurons above threshold -> spike_cnt=256 after done.

Source files
------------

// File: rtl/neuron_scan.sv
// Timestep sweep sequencer: reads each neuron's amplitudes, decays them by shift,
// and compares the membrane value (A - B) against a threshold to produce spikes.
module neuron_scan #(
  parameter int NEURON_NO = 2**8,
  parameter int AMPL_WID  = 12,
  parameter int TAU_A_SH  = 4,
  parameter int TAU_B_SH  = 2,
  localparam int IDX_W    = $clog2(NEURON_NO)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [AMPL_WID-1:0] threshold,
  input  logic [AMPL_WID-1:0] ampl_a,
  input  logic [AMPL_WID-1:0] ampl_b,
  output logic                re,
  output logic [IDX_W-1:0]    rd_addr,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [AMPL_WID-1:0] ker_a,
  output logic [AMPL_WID-1:0] ker_b,
  output logic                ker_valid,
  output logic                sp_out,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      spike_cnt,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t              state, next_state;
  logic [IDX_W-1:0]    index;
  logic                drain_cnt;
  logic                p1_valid;
  logic [IDX_W-1:0]    p1_addr;
  logic [IDX_W:0]      acc;
  logic [AMPL_WID-1:0] ka_d, kb_d;
  logic [AMPL_WID:0]   v;
  logic                fire;
  logic                start;
  logic                last_drain;

  // The done cycle still counts as busy for tick purposes even though busy is low.
  assign start      = tick && !done;
  assign last_drain = (state == DRAIN) && drain_cnt;

  always_comb begin
    next_state = state;
    re         = 1'b0;
    rd_addr    = '0;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = SCAN;
      SCAN: begin
        re      = 1'b1;
        rd_addr = index;
        busy    = 1'b1;
        if (index == '1) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ka_d = ampl_a - (ampl_a >> TAU_A_SH);
    kb_d = ampl_b - (ampl_b >> TAU_B_SH);
    v    = {1'b0, ka_d} - {1'b0, kb_d};
    fire = !v[AMPL_WID] && (v[AMPL_WID-1:0] >= threshold);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      drain_cnt <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) index <= '0;
      else if (state == SCAN)     index <= index + IDX_W'(1);
      drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
      if (tick && (state != IDLE || done)) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid  <= 1'b0;
      p1_addr   <= '0;
      ker_valid <= 1'b0;
      wr_addr   <= '0;
      ker_a     <= '0;
      ker_b     <= '0;
      sp_out    <= 1'b0;
    end else begin
      p1_valid  <= re;
      p1_addr   <= rd_addr;
      ker_valid <= p1_valid;
      wr_addr   <= p1_valid ? p1_addr : '0;
      ker_a     <= p1_valid ? ka_d : '0;
      ker_b     <= p1_valid ? kb_d : '0;
      sp_out    <= p1_valid && fire;
    end
  end

  // The final neuron's spike is folded in directly so spike_cnt is current when done pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      spike_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_drain;
      if (last_drain) begin
        spike_cnt <= acc + (IDX_W+1)'(sp_out);
        acc       <= '0;
      end else if (sp_out) begin
        acc <= acc + (IDX_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuron_scan.sv
// Scoreboard bench for neuron_scan: expected kernels/spikes queued per sweep,
// popped by a monitor whenever ker_valid is presented.
module tb_neuron_scan;

  localparam int N  = 256;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic [AW-1:0] threshold = '0;
  logic [AW-1:0] ampl_a = '0, ampl_b = '0;
  logic          re, ker_valid, sp_out, busy, done, overrun;
  logic [7:0]    rd_addr, wr_addr;
  logic [AW-1:0] ker_a, ker_b;
  logic [8:0]    spike_cnt;

  neuron_scan #(.NEURON_NO(N), .AMPL_WID(AW), .TAU_A_SH(4), .TAU_B_SH(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .threshold(threshold),
    .ampl_a(ampl_a), .ampl_b(ampl_b), .re(re), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .ker_a(ker_a), .ker_b(ker_b), .ker_valid(ker_valid),
    .sp_out(sp_out), .busy(busy), .done(done), .spike_cnt(spike_cnt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    addr;
    logic [AW-1:0] ka;
    logic [AW-1:0] kb;
    logic          sp;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] mem_a[N], mem_b[N];
  logic [AW-1:0] ea[N], eb[N];
  logic          es[N];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, tick_cyc = 0, done_cnt = 0, exp_rd = 0, exp_spk = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Amplitude store model: one-cycle read latency.
  initial begin : store
    logic          r;
    logic [7:0]    a;
    forever begin
      @(negedge clk);
      r = re;
      a = rd_addr;
      @(posedge clk);
      #1;
      ampl_a = r ? mem_a[a] : '0;
      ampl_b = r ? mem_b[a] : '0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (re && reset) begin
      check("rd_addr", int'(rd_addr), exp_rd);
      exp_rd++;
    end
    if (ker_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_ker_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", int'(wr_addr), int'(e.addr));
        check("ker_a", int'(ker_a), int'(e.ka));
        check("ker_b", int'(ker_b), int'(e.kb));
        check("sp_out", int'(sp_out), int'(e.sp));
      end
    end
    if (done) begin
      done_cnt++;
      check("done_latency", cyc - tick_cyc, N + 3);
      check("sb_empty_at_done", sb.size(), 0);
      check("spike_cnt", int'(spike_cnt), exp_spk);
      check("busy_at_done", int'(busy), 0);
    end
  end

  task automatic set_exp_default(input logic [AW-1:0] ka, input logic [AW-1:0] kb,
                                 input logic sp);
    for (int i = 0; i < N; i++) begin
      ea[i] = ka; eb[i] = kb; es[i] = sp;
    end
  endtask

  task automatic push_sweep();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.addr = 8'(i); e.ka = ea[i]; e.kb = eb[i]; e.sp = es[i];
      sb.push_back(e);
    end
  endtask

  task automatic pulse_tick(input bit real_start);
    @(negedge clk);
    tick = 1'b1;
    if (real_start) begin
      tick_cyc = cyc;
      exp_rd   = 0;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic run_sweep(input int spk, input int ovr_at);
    int d0;
    bit seen;
    d0      = done_cnt;
    exp_spk = spk;
    seen    = 0;
    push_sweep();
    pulse_tick(1);
    for (int i = 0; i < 400 && !seen; i++) begin
      if (i == ovr_at) pulse_tick(0);
      else @(negedge clk);
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (5) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
  endtask

  initial begin : main
    int guard;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0; mem_b[i] = '0;
    end
    #23;
    check("rst_re", int'(re), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ker_valid", int'(ker_valid), 0);
    check("rst_spike_cnt", int'(spike_cnt), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // all zero amplitudes, threshold 1: nothing fires
    threshold = 12'h001;
    set_exp_default('0, '0, 1'b0);
    run_sweep(0, -1);

    // neuron 5 fires, neuron 7 negative
    mem_a[5] = 12'h100; mem_b[5] = 12'h010;
    mem_a[7] = 12'h010; mem_b[7] = 12'h080;
    threshold = 12'h0E0;
    set_exp_default('0, '0, 1'b0);
    ea[5] = 12'h0F0; eb[5] = 12'h00C; es[5] = 1'b1;
    ea[7] = 12'h00F; eb[7] = 12'h060; es[7] = 1'b0;
    run_sweep(1, -1);

    // threshold 0: zeros fire, negative v never does
    threshold = 12'h000;
    set_exp_default('0, '0, 1'b1);
    ea[5] = 12'h0F0; eb[5] = 12'h00C; es[5] = 1'b1;
    ea[7] = 12'h00F; eb[7] = 12'h060; es[7] = 1'b0;
    run_sweep(255, -1);

    // boundary decay just below threshold, with an overrun tick mid-sweep
    mem_a[9] = 12'hFFF; mem_b[9] = 12'h001;
    threshold = 12'hF00;
    set_exp_default('0, '0, 1'b0);
    ea[5] = 12'h0F0; eb[5] = 12'h00C;
    ea[7] = 12'h00F; eb[7] = 12'h060;
    ea[9] = 12'hF00; eb[9] = 12'h001;
    check("overrun_before", int'(overrun), 0);
    run_sweep(0, 100);
    check("overrun_set", int'(overrun), 1);

    // threshold exactly at v = 0xEFF
    threshold = 12'hEFF;
    es[9] = 1'b1;
    run_sweep(1, -1);
    check("overrun_sticky", int'(overrun), 1);

    // reset mid-scan at index 40
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0; mem_b[i] = '0;
    end
    threshold = 12'h001;
    set_exp_default('0, '0, 1'b0);
    push_sweep();
    pulse_tick(1);
    guard = 0;
    while (!(re && rd_addr == 8'd40) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reached_idx40", int'(rd_addr), 40);
    #1 reset = 1'b0;
    #1;
    check("midrst_re", int'(re), 0);
    check("midrst_ker_valid", int'(ker_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sp_out", int'(sp_out), 0);
    check("midrst_spike_cnt", int'(spike_cnt), 0);
    check("midrst_overrun", int'(overrun), 0);
    sb.delete();
    guard = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("no_done_after_rst", done_cnt - guard, 0);

    // every neuron fires: count reaches NEURON_NO
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 12'h800; mem_b[i] = '0;
    end
    threshold = 12'h001;
    set_exp_default(12'h780, '0, 1'b1);
    run_sweep(256, -1);
    check("spike_cnt_hold", int'(spike_cnt), 256);
    check("final_overrun", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
